// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared phase/owner encodings and default widths for the RAM port arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        PH_LOAD = 2'd0,
        PH_RUN  = 2'd1,
        PH_DUMP = 2'd2
    } phase_t;

    // Owner tags double as bit positions in the request/grant vectors.
    localparam logic OWN_U = 1'b0;
    localparam logic OWN_C = 1'b1;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with eligibility mask and one-hot grant
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic       last;
    logic [1:0] act;

    // On contention the requester that did not win most recently takes the slot.
    always_comb begin
        act = req & elig;
        gnt = 2'b00;
        case (act)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_C) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            last <= OWN_U;
        end else if (gnt != 2'b00) begin
            last <= gnt[OWN_C];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - phase sequencer and round-robin sharing of the single-port RAM
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              u_req,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    output logic              u_gnt,
    output logic              u_rvalid,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              uart_done,
    input  logic              end_ops,
    input  logic              dump_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        phase,
    output logic              core_run
);

    phase_t            state;
    phase_t            state_nxt;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              win_any;
    logic              win_c;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              rd_issue;
    logic [RD_LAT-1:0] tag_vld;
    logic [RD_LAT-1:0] tag_own;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= PH_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Each done flag only counts in the phase it terminates.
    always_comb begin
        state_nxt = state;
        phase     = state;
        core_run  = 1'b0;
        elig      = 2'b01;
        case (state)
            PH_LOAD: if (uart_done) state_nxt = PH_RUN;
            PH_RUN: begin
                core_run = 1'b1;
                elig     = 2'b11;
                if (end_ops) state_nxt = PH_DUMP;
            end
            PH_DUMP: if (dump_done) state_nxt = PH_LOAD;
            default: state_nxt = PH_LOAD;
        endcase
    end

    rr_arbiter2 u_rr (
        .clk_in (clk_in),
        .rst    (rst),
        .req    ({c_req, u_req}),
        .elig   (elig),
        .gnt    (gnt)
    );

    assign u_gnt     = gnt[OWN_U];
    assign c_gnt     = gnt[OWN_C];
    assign win_any   = |gnt;
    assign win_c     = gnt[OWN_C];
    assign win_we    = win_c ? c_we : u_we;
    assign win_addr  = win_c ? c_addr : u_addr;
    assign win_wdata = win_c ? c_wdata : u_wdata;
    assign rd_issue  = win_any & ~win_we;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we <= win_any & win_we;
            if (win_any) begin
                ram_addr  <= win_addr;
                ram_wdata <= win_wdata;
            end
        end
    end

    // Reads carry their owner through the RAM latency so a phase change cannot misroute them.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            tag_vld  <= '0;
            tag_own  <= '0;
            u_rvalid <= 1'b0;
            c_rvalid <= 1'b0;
            rdata    <= '0;
        end else begin
            tag_vld  <= RD_LAT'({tag_vld, rd_issue});
            tag_own  <= RD_LAT'({tag_own, win_c});
            u_rvalid <= tag_vld[RD_LAT-1] & (tag_own[RD_LAT-1] == OWN_U);
            c_rvalid <= tag_vld[RD_LAT-1] & (tag_own[RD_LAT-1] == OWN_C);
            if (tag_vld[RD_LAT-1]) begin
                rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int   RD_LAT = 1;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk_in = 1'b0;
    logic        rst;
    logic        u_req, u_we, c_req, c_we;
    logic [15:0] u_addr, c_addr;
    logic [7:0]  u_wdata, c_wdata;
    logic        u_gnt, u_rvalid, c_gnt, c_rvalid;
    logic [7:0]  rdata;
    logic        uart_done, end_ops, dump_done;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic        ram_we;
    logic [1:0]  phase;
    logic        core_run;

    always #5 clk_in = ~clk_in;

    ram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(RD_LAT)) dut (
        .clk_in(clk_in), .rst(rst),
        .u_req(u_req), .u_we(u_we), .u_addr(u_addr), .u_wdata(u_wdata),
        .u_gnt(u_gnt), .u_rvalid(u_rvalid),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .rdata(rdata), .uart_done(uart_done), .end_ops(end_ops), .dump_done(dump_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .phase(phase), .core_run(core_run)
    );

    // Behavioural RAM: address registered by the DUT, data back one cycle later.
    logic [7:0] mem [0:65535];
    always @(posedge clk_in or posedge rst) begin
        if (rst) begin
            foreach (mem[i]) mem[i] <= 8'h00;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    typedef struct packed {
        logic        ur, uw;
        logic [15:0] ua;
        logic [7:0]  ud;
        logic        cr, cw;
        logic [15:0] ca;
        logic [7:0]  cd;
        logic        fu, fe, fd;
        logic        eu, ec;
        logic [1:0]  eph;
    } vec_t;

    typedef struct {
        int         due;
        logic       own;
        logic [7:0] data;
    } rd_t;

    int         checks;
    int         errors;
    int         cyc;
    int         m_phase;
    logic       m_last;
    logic       m_bus, m_we;
    logic [15:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] mmem [0:65535];
    rd_t        rdq[$];
    vec_t       tab [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_last  = 1'b0;
        m_bus   = 1'b0;
        m_we    = 1'b0;
        rdq.delete();
        foreach (mmem[i]) mmem[i] = 8'h00;
    endtask

    task automatic drive_idle();
        u_req = 0; u_we = 0; u_addr = 0; u_wdata = 0;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        uart_done = 0; end_ops = 0; dump_done = 0;
    endtask

    // One clock: drive at the falling edge, check half a cycle before the rising edge, advance model.
    task automatic cycle(input vec_t v, input bit use_tab, output logic gu, output logic gc);
        logic       wu, wc, own, we;
        logic [15:0] a;
        logic [7:0] d;
        rd_t        r;
        @(negedge clk_in);
        u_req = v.ur; u_we = v.uw; u_addr = v.ua; u_wdata = v.ud;
        c_req = v.cr; c_we = v.cw; c_addr = v.ca; c_wdata = v.cd;
        uart_done = v.fu; end_ops = v.fe; dump_done = v.fd;
        #1;
        wu = v.ur;
        wc = v.cr && (m_phase == 1);
        if (wu && wc) begin
            if (m_last) wc = 1'b0;
            else        wu = 1'b0;
        end
        chk("u_gnt", u_gnt, wu);
        chk("c_gnt", c_gnt, wc);
        chk("phase", phase, m_phase);
        chk("core_run", core_run, m_phase == 1);
        chk("ram_we", ram_we, m_we);
        if (m_bus) begin
            chk("ram_addr", ram_addr, m_addr);
            if (m_we) chk("ram_wdata", ram_wdata, m_wdata);
        end
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            chk("u_rvalid", u_rvalid, rdq[0].own == 1'b0);
            chk("c_rvalid", c_rvalid, rdq[0].own == 1'b1);
            chk("rdata", rdata, rdq[0].data);
            void'(rdq.pop_front());
        end else begin
            chk("u_rvalid_idle", u_rvalid, 0);
            chk("c_rvalid_idle", c_rvalid, 0);
        end
        if (use_tab) begin
            chk("tab_u_gnt", u_gnt, v.eu);
            chk("tab_c_gnt", c_gnt, v.ec);
            chk("tab_phase", phase, v.eph);
        end
        m_bus = wu | wc;
        m_we  = 1'b0;
        if (m_bus) begin
            own = wc;
            we  = wc ? v.cw : v.uw;
            a   = wc ? v.ca : v.ua;
            d   = wc ? v.cd : v.ud;
            m_we = we; m_addr = a; m_wdata = d; m_last = own;
            if (we) begin
                mmem[a] = d;
            end else begin
                r.due = cyc + 1 + RD_LAT; r.own = own; r.data = mmem[a];
                rdq.push_back(r);
            end
        end
        case (m_phase)
            0: if (v.fu) m_phase = 1;
            1: if (v.fe) m_phase = 2;
            2: if (v.fd) m_phase = 0;
            default: m_phase = 0;
        endcase
        cyc++;
        gu = wu;
        gc = wc;
    endtask

    // Random requesters that honour the hold-until-grant rule and may withdraw.
    task automatic rand_run(input int n);
        vec_t r;
        logic gu, gc;
        r = '0; gu = 1'b1; gc = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (!r.ur || gu) begin
                r.ur = ($urandom_range(0, 99) < 55);
                r.uw = 1'($urandom_range(0, 1));
                r.ua = 16'($urandom_range(0, 15));
                r.ud = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                r.ur = 1'b0;
            end
            if (!r.cr || gc) begin
                r.cr = ($urandom_range(0, 99) < 55);
                r.cw = 1'($urandom_range(0, 1));
                r.ca = 16'($urandom_range(0, 15));
                r.cd = 8'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                r.cr = 1'b0;
            end
            r.fu = ($urandom_range(0, 19) == 0);
            r.fe = ($urandom_range(0, 29) == 0);
            r.fd = ($urandom_range(0, 19) == 0);
            cycle(r, 1'b0, gu, gc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after 200000 time units, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t r;
        logic gu, gc;
        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        drive_idle();
        model_reset();

        //             ur uw ua        ud     cr cw ca        cd     fu fe fd eu ec eph
        tab[0]  = '{H, H, 16'h0000, 8'hA0, H, L, 16'h0010, 8'h00, L, L, L, H, L, 2'd0};
        tab[1]  = '{H, H, 16'h0001, 8'hA1, H, L, 16'h0010, 8'h00, L, L, L, H, L, 2'd0};
        tab[2]  = '{H, H, 16'h0002, 8'hA2, H, L, 16'h0010, 8'h00, L, L, L, H, L, 2'd0};
        tab[3]  = '{H, H, 16'h0003, 8'hA3, H, L, 16'h0010, 8'h00, L, L, L, H, L, 2'd0};
        tab[4]  = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, H, L, L, L, L, 2'd0};
        tab[5]  = '{L, L, 16'h0000, 8'h00, H, L, 16'h0002, 8'h00, L, L, L, L, H, 2'd1};
        tab[6]  = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, L, L, L, L, L, 2'd1};
        tab[7]  = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, L, L, L, L, L, 2'd1};
        tab[8]  = '{H, L, 16'h0003, 8'h00, L, L, 16'h0000, 8'h00, L, L, L, H, L, 2'd1};
        tab[9]  = '{H, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, L, H, 2'd1};
        tab[10] = '{H, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, H, L, 2'd1};
        tab[11] = '{H, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, L, H, 2'd1};
        tab[12] = '{H, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, H, L, 2'd1};
        tab[13] = '{L, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, H, L, L, H, 2'd1};
        tab[14] = '{L, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, L, L, 2'd2};
        tab[15] = '{L, L, 16'h0000, 8'h00, H, L, 16'h0001, 8'h00, L, L, L, L, L, 2'd2};
        tab[16] = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, H, H, L, L, L, 2'd2};
        tab[17] = '{H, L, 16'h0003, 8'h00, L, L, 16'h0000, 8'h00, L, L, L, H, L, 2'd2};
        tab[18] = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, L, L, H, L, L, 2'd2};
        tab[19] = '{L, L, 16'h0000, 8'h00, L, L, 16'h0000, 8'h00, L, L, L, L, L, 2'd0};

        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_u_rvalid", u_rvalid, 0);
        chk("rst_c_rvalid", c_rvalid, 0);
        chk("rst_phase", phase, 0);
        chk("rst_core_run", core_run, 0);
        @(negedge clk_in);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) cycle(tab[i], 1'b1, gu, gc);

        rand_run(300);

        for (int k = 0; k < 4 && m_phase != 1; k++) begin
            r = '0;
            r.fu = (m_phase == 0);
            r.fd = (m_phase == 2);
            cycle(r, 1'b0, gu, gc);
        end
        r = '0; r.ur = 1'b1; r.uw = 1'b1; r.ua = 16'h8000; r.ud = 8'h5A;
        cycle(r, 1'b0, gu, gc);
        r.uw = 1'b0; r.ua = 16'h8001;
        cycle(r, 1'b0, gu, gc);
        rst = 1'b1;
        drive_idle();
        #1;
        chk("midrst_ram_we", ram_we, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_phase", phase, 0);
        chk("midrst_core_run", core_run, 0);
        repeat (3) begin
            @(negedge clk_in);
            #1;
            chk("midrst_u_rvalid", u_rvalid, 0);
            chk("midrst_c_rvalid", c_rvalid, 0);
            chk("midrst_ram_we_hold", ram_we, 0);
        end
        @(negedge clk_in);
        rst = 1'b0;
        model_reset();
        r = '0;
        repeat (4) cycle(r, 1'b0, gu, gc);

        rand_run(150);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the UART loader/dumper (port U) and the processor core (port C).
- Sequences the system phases LOAD -> RUN -> DUMP -> LOAD, driven by the UART completion and end-of-operations flags.
- Within RUN, round-robin arbitrates between both ports.
- Sits between the UART block, the core and the RAM; it is the only driver of the RAM address, data and write-enable pins.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles after the address is registered (synchronous RAM).

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- u_req  in  1  UART access request; held with u_addr/u_we/u_wdata until u_gnt.
- u_we  in  1  UART write (1) / read (0).
- u_addr  in  ADDR_W  UART address.
- u_wdata  in  DATA_W  UART write data.
- u_gnt  out  1  combinational accept pulse, same cycle as the winning u_req.
- u_rvalid  out  1  UART read data valid on rdata.
- c_req, c_we, c_addr, c_wdata, c_gnt, c_rvalid: same meanings and widths for the core.
- rdata  out  DATA_W  registered RAM read data, shared by both ports; qualify with *_rvalid.
- uart_done  in  1  UART load finished (level or pulse).
- end_ops  in  1  core finished execution.
- dump_done  in  1  UART dump finished.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_rdata  in  DATA_W  RAM read data.
- phase  out  2  0=LOAD, 1=RUN, 2=DUMP.
- core_run  out  1  high only in RUN; releases the core.

Behaviour:
- Reset values: phase=LOAD, core_run=0, ram_we=0, ram_addr=0, ram_wdata=0, rdata=0, all gnt/rvalid=0, RR pointer favours C, read pipeline flushed.
- Reset mid-access: the in-flight write is dropped (ram_we=0 immediately) and pending rvalid is never issued.
- Phase FSM:
  - LOAD -> RUN on uart_done.
  - RUN -> DUMP on end_ops.
  - DUMP -> LOAD on dump_done.
  - Done flags outside their phase are ignored.
  - Phase changes take effect the cycle after the flag is sampled.
- Eligibility per phase:
  - LOAD and DUMP: only U is eligible; c_gnt=0.
  - RUN: both eligible. Only one requesting: that one wins. Both requesting: the one not granted most recently wins.
  - The RR pointer updates only on a grant.
- Access timing (one access per cycle max, back-to-back allowed):
  - Cycle N: requester's req high and eligible; gnt=1 combinationally in N.
  - Cycle N+1: ram_addr/ram_wdata/ram_we registered from the winner; ram_we=1 only for a write.
  - Read: rdata registered from ram_rdata and owner's rvalid=1 in cycle N+1+RD_LAT (N+2 by default).
  - Write: no rvalid.
  - ram_we is deasserted in any cycle without a write grant.
- Read tagging: each issued read is tagged with its owner and carried through the RD_LAT pipeline. A phase change never redirects or kills an in-flight rvalid; it is delivered to the original owner.
- Same cycle as a phase flag: arbitration uses the current (pre-change) phase.
- Requester rules:
  - A requester must hold req and its addr/we/wdata stable until gnt.
  - Dropping req before gnt is legal; nothing is issued.
  - A requester may keep req high for consecutive accesses with new addr each cycle.
- Addresses pass through unmodified; no wrap logic in this block.

Decomposition:
- Shared package ram_arb_pkg:
  - Phase encoding constants PH_LOAD/PH_RUN/PH_DUMP.
  - Owner tag constants OWN_U/OWN_C.
  - Default ADDR_W/DATA_W.
- One natural sub-module: rr_arbiter2. It is a two-input round-robin arbiter with an eligibility mask, a last-grant register, and a one-hot grant output. The phase FSM, RAM registers and read-tag pipeline stay in the top.

Test Plan:
- Reset then u_req write addr 0x0000..0x0003, data 0xA0..0xA3, back-to-back -> u_gnt each cycle; ram_we=1 with matching addr/data one cycle later; c_req held high throughout -> c_gnt stays 0.
- Pulse uart_done, then c_req read 0x0002 -> phase=1 and core_run=1 next cycle; c_gnt same cycle; c_rvalid=1 with rdata=0xA2 two cycles after grant.
- RUN, u_req and c_req both held high for 4 cycles with reads -> grants alternate C,U,C,U (pointer favours C after reset); rvalids alternate with correct owner.
- Issue c_req read 0x0001, and assert end_ops in the same cycle -> the read is granted (RUN rules); c_rvalid still delivered with 0xA1; phase=2 next cycle; subsequent c_req ignored.
- DUMP: pulse uart_done and end_ops -> no phase change. Pulse dump_done -> phase=0; core_run stays 0.
- Assert rst one cycle after a write grant -> ram_we=0 immediately; all rvalid stay 0; phase=LOAD after release.
